fpga_cmd_dispatch: RTL
======================

// Module: fpga_cmd_dispatch
// PURPOSE
//  Successor to the fixed two-interface FPGA controller: pops command words from the host-side input FIFO.
//  Decodes a header, address and optional data word, then dispatches one transaction to any of NUM_CH
//  chip-interface masters (I2C, SPI, ...). Read results, write acks and error words go to the output FIFO.
//  Sits between the FIFO pair and the per-protocol master cores.
// PARAMETERS
//  NUM_CH      2      number of interface-master channels (1..16)
//  DW          32     FIFO word / address / data width (>=32)
//  TIMEOUT_CYC 65535  max cycles from issue to completion before abort (>=4)
//  WR_ACK      0      1: push ack word after every completed write; 0: writes silent
// PORTS
//  CLK         in  1          process clock
//  rst         in  1          asynchronous, active-high reset
//  fa_dout     in  DW         input FIFO data, standard mode (valid 1 cycle after fa_ren)
//  fa_empty    in  1          input FIFO empty
//  fa_ren      out 1          input FIFO read enable (1-cycle pulse per word)
//  fb_din      out DW         output FIFO write data
//  fb_wen      out 1          output FIFO write enable
//  fb_full     in  1          output FIFO full
//  ch_valid    out NUM_CH     one-hot 1-cycle transaction strobe to selected channel
//  ch_rw       out 1          1=read, 0=write (shared, held through transaction)
//  ch_slave    out 7          slave address (shared, held)
//  ch_addr     out DW         register address (shared, held)
//  ch_wdata    out DW         write data (shared, held)
//  ch_busy     in  NUM_CH     per-channel busy
//  ch_rd_valid in  NUM_CH     per-channel read-data strobe
//  ch_rd_data  in  NUM_CH*DW  per-channel read data, channel c at [c*DW +: DW]
//  busy        out 1          high whenever state != IDLE
//  err_cnt     out 8          saturating count of error words pushed
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; registers cleared. Reset mid-transaction aborts it, no FIFO write.
//  Header word: [31]=rw, [30:24]=slave, [23:20]=ch, [19:0] ignored. Next word=addr; if write, next=wdata.
//  FSM: IDLE -> RD_HDR -> LAT_HDR -> RD_ADDR -> LAT_ADDR -> (write: RD_DAT -> LAT_DAT) -> ISSUE -> WAIT -> PUSH -> IDLE.
//  RD_* states: pulse fa_ren only when fa_empty=0, else stall in place; LAT_* captures fa_dout next cycle.
//  Command word latency: 2 cycles each when FIFO non-empty; ch_valid earliest 1 cycle after last LAT_*.
//  ch >= NUM_CH: full command still consumed (no desync). ISSUE skipped; PUSH error 0xEE00_00cc (cc=ch).
//  ISSUE: waits while ch_busy[ch]=1. When 0, ch_valid[ch]=1 for exactly one cycle, timeout counter cleared.
//  WAIT: first cycle after ch_valid is blanking (ch_busy ignored, ch_rd_valid still accepted).
//   read completes on ch_rd_valid[ch]; data captured that cycle.
//   write completes when ch_busy[ch]=0 after blanking.
//   strobes from other channels ignored.
//   counter reaching TIMEOUT_CYC -> abort, PUSH 0xEE01_00cc.
//  PUSH: holds while fb_full=1; writes one word with fb_wen=1 for 1 cycle, then IDLE.
//   read -> captured data; write with WR_ACK=1 -> 0xAC00_00cc; write with WR_ACK=0 -> PUSH skipped.
//  err_cnt increments on each error word pushed; saturates at 255 (no wrap).
//  ch_rw/ch_slave/ch_addr/ch_wdata stable from ISSUE until next LAT_HDR. Upper header bits zero-extend when DW>32.
//  One transaction in flight; no new fa_ren until PUSH done.
// TESTING
//  1 Write: hdr 0x0A10_0000, addr 0x10, data 0x55 -> ch_valid=2'b10 once, ch_wdata=0x55; no fb_wen (WR_ACK=0).
//  2 Read: ch0, ch_rd_valid after 20 cycles, data 0x1234_5678 -> fb_din=0x1234_5678, one fb_wen pulse.
//  3 Bad channel: hdr ch=5, NUM_CH=2 -> 2/3 words popped, fb_din=0xEE00_0005, err_cnt=1, next cmd runs.
//  4 Timeout: TIMEOUT_CYC=16, read with no strobe -> fb_din=0xEE01_0000 at cycle 16; busy low next.
//  5 Backpressure/stall: fa_empty between words and fb_full=1 at PUSH -> FSM holds, no lost/dup words.
//  6 rst pulse in WAIT -> outputs 0, no fb_wen; 300 errors -> err_cnt=255.

Source files
------------

// File: rtl/fpga_cmd_dispatch.sv
// fpga_cmd_dispatch
//   Pops command words from the host input FIFO (header, address and, for
//   writes, a data word). It then dispatches a single transaction to one of
//   NUM_CH interface-master channels. Read data, optional write acks and
//   error words are returned through the output FIFO. Only one transaction
//   is in flight at a time.
//
//   Header word: [31]=rw (1=read), [30:24]=slave, [23:20]=channel, rest ignored.
//   Status words: 0xEE00_00cc bad channel, 0xEE01_00cc timeout, 0xAC00_00cc write ack.
//
// Ports
//   CLK, rst               clock, asynchronous active-high reset
//   fa_dout/fa_empty/fa_ren input FIFO (data valid the cycle after fa_ren)
//   fb_din/fb_wen/fb_full   output FIFO
//   ch_valid                one-hot single-cycle strobe to the selected channel
//   ch_rw/ch_slave/ch_addr/ch_wdata  shared transaction fields, held
//   ch_busy/ch_rd_valid/ch_rd_data   per-channel status and read return
//   busy                    high whenever the controller is not idle
//   err_cnt                 saturating count of error words pushed
module fpga_cmd_dispatch #(
  parameter int NUM_CH      = 2,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 65535,
  parameter int WR_ACK      = 0
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [DW-1:0]        fa_dout,
  input  logic                 fa_empty,
  output logic                 fa_ren,
  output logic [DW-1:0]        fb_din,
  output logic                 fb_wen,
  input  logic                 fb_full,
  output logic [NUM_CH-1:0]    ch_valid,
  output logic                 ch_rw,
  output logic [6:0]           ch_slave,
  output logic [DW-1:0]        ch_addr,
  output logic [DW-1:0]        ch_wdata,
  input  logic [NUM_CH-1:0]    ch_busy,
  input  logic [NUM_CH-1:0]    ch_rd_valid,
  input  logic [NUM_CH*DW-1:0] ch_rd_data,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_HDR, S_LAT_HDR, S_RD_ADDR, S_LAT_ADDR,
    S_RD_DAT, S_LAT_DAT, S_ISSUE, S_WAIT, S_PUSH
  } state_t;

  state_t          r_state, w_next;
  logic            r_rw;
  logic [6:0]      r_slave;
  logic [3:0]      r_ch;
  logic [DW-1:0]   r_addr, r_wdata, r_out;
  logic            r_is_err, r_blank;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_err_cnt;

  logic            w_sel_busy, w_sel_rdv, w_bad, w_issue;
  logic [DW-1:0]   w_sel_data;
  logic            w_rd_done, w_wr_done, w_tmo;

  // Status word: 16-bit tag, channel number in the low nibble, zero-extended.
  function automatic logic [DW-1:0] status_word(input logic [15:0] tag, input logic [3:0] ch);
    logic [DW-1:0] w;
    w = '0;
    w[31:0] = {tag, 12'h000, ch};
    return w;
  endfunction

  // Select the addressed channel's status; an out-of-range channel selects nothing.
  always_comb begin
    w_sel_busy = 1'b0;
    w_sel_rdv  = 1'b0;
    w_sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == 4'(c)) begin
        w_sel_busy = ch_busy[c];
        w_sel_rdv  = ch_rd_valid[c];
        w_sel_data = ch_rd_data[c*DW +: DW];
      end
    end
  end

  assign w_bad     = (int'(r_ch) >= NUM_CH);
  assign w_rd_done = r_rw && w_sel_rdv;
  // The first WAIT cycle ignores busy: masters raise it a cycle after the strobe.
  assign w_wr_done = !r_rw && !r_blank && !w_sel_busy;
  assign w_tmo     = (r_tmo >= TW'(TIMEOUT_CYC));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    fa_ren   = 1'b0;
    fb_wen   = 1'b0;
    w_issue  = 1'b0;
    ch_valid = '0;
    case (r_state)
      S_IDLE:     if (!fa_empty) w_next = S_RD_HDR;
      S_RD_HDR:   if (!fa_empty) begin fa_ren = 1'b1; w_next = S_LAT_HDR; end
      S_LAT_HDR:  w_next = S_RD_ADDR;
      S_RD_ADDR:  if (!fa_empty) begin fa_ren = 1'b1; w_next = S_LAT_ADDR; end
      S_LAT_ADDR: begin
        if (!r_rw)      w_next = S_RD_DAT;
        else if (w_bad) w_next = S_PUSH;
        else            w_next = S_ISSUE;
      end
      S_RD_DAT:   if (!fa_empty) begin fa_ren = 1'b1; w_next = S_LAT_DAT; end
      S_LAT_DAT:  w_next = w_bad ? S_PUSH : S_ISSUE;
      S_ISSUE:    if (!w_sel_busy) begin w_issue = 1'b1; w_next = S_WAIT; end
      S_WAIT: begin
        if (w_rd_done)      w_next = S_PUSH;
        else if (w_wr_done) w_next = (WR_ACK != 0) ? S_PUSH : S_IDLE;
        else if (w_tmo)     w_next = S_PUSH;
      end
      S_PUSH:     if (!fb_full) begin fb_wen = 1'b1; w_next = S_IDLE; end
      default:    w_next = S_IDLE;
    endcase
    for (int c = 0; c < NUM_CH; c++) ch_valid[c] = w_issue && (r_ch == 4'(c));
  end

  // Command capture, completion tracking and result staging
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_rw      <= 1'b0;
      r_slave   <= '0;
      r_ch      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_out     <= '0;
      r_is_err  <= 1'b0;
      r_blank   <= 1'b0;
      r_tmo     <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_LAT_HDR: begin
          r_rw    <= fa_dout[31];
          r_slave <= fa_dout[30:24];
          r_ch    <= fa_dout[23:20];
        end
        S_LAT_ADDR: begin
          r_addr <= fa_dout;
          if (r_rw && w_bad) begin
            r_out    <= status_word(16'hEE00, r_ch);
            r_is_err <= 1'b1;
          end
        end
        S_LAT_DAT: begin
          r_wdata <= fa_dout;
          if (w_bad) begin
            r_out    <= status_word(16'hEE00, r_ch);
            r_is_err <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Counter counts the strobe cycle too, so it reads 1 in the first WAIT cycle.
          if (!w_sel_busy) begin
            r_tmo   <= TW'(1);
            r_blank <= 1'b1;
          end
        end
        S_WAIT: begin
          r_blank <= 1'b0;
          if (w_rd_done) begin
            r_out    <= w_sel_data;
            r_is_err <= 1'b0;
          end else if (w_wr_done) begin
            r_out    <= status_word(16'hAC00, r_ch);
            r_is_err <= 1'b0;
          end else if (w_tmo) begin
            r_out    <= status_word(16'hEE01, r_ch);
            r_is_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_PUSH: begin
          if (!fb_full && r_is_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign fb_din   = r_out;
  assign ch_rw    = r_rw;
  assign ch_slave = r_slave;
  assign ch_addr  = r_addr;
  assign ch_wdata = r_wdata;
  assign busy     = (r_state != S_IDLE);
  assign err_cnt  = r_err_cnt;

endmodule
